// File: rtl/util_axis_uart_rx_os.sv
// Oversampling UART receiver: 2-flop synchronized rx, majority-voted mid-bit sampling,
// single-entry AXI-Stream output with parity/framing flags and an overflow pulse.
module util_axis_uart_rx_os #(
    parameter int clock_speed = 50000000,
    parameter int baud_rate   = 781250,
    parameter int oversample  = 16,
    parameter int parity_ena  = 0,
    parameter int parity_type = 0,
    parameter int stop_bits   = 1,
    parameter int data_bits   = 8
) (
    input  logic       aclk,
    input  logic       arstn,
    input  logic       rx,
    output logic [7:0] m_axis_tdata,
    output logic [1:0] m_axis_tuser,
    output logic       m_axis_tvalid,
    input  logic       m_axis_tready,
    output logic       overflow
);
    localparam int DIV_RAW = clock_speed / (baud_rate * oversample);
    localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int DW      = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int OW      = $clog2(oversample);
    localparam int S0      = oversample / 2 - 1;
    localparam int S1      = oversample / 2;
    localparam int S2      = oversample / 2 + 1;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BRK} state_t;

    state_t                 state, next;
    logic                   rx_m, rx_s, rx_q;
    logic [DW-1:0]          div_cnt;
    logic [OW-1:0]          os_cnt;
    logic                   tick, start_det, decide, maj, done, done_q;
    logic [1:0]             samp;
    logic [2:0]             bit_cnt;
    logic [data_bits-1:0]   data_sr;
    logic                   perr, ferr;

    assign tick      = (div_cnt == DW'(DIV - 1));
    assign start_det = (state == IDLE) && !rx_s && rx_q;
    assign decide    = tick && (os_cnt == OW'(S2));
    assign maj       = (samp[0] & samp[1]) | (samp[0] & rx_s) | (samp[1] & rx_s);

    always_ff @(posedge aclk or negedge arstn) begin
        if (!arstn) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
            rx_q <= 1'b1;
        end else begin
            rx_m <= rx;
            rx_s <= rx_m;
            rx_q <= rx_s;
        end
    end

    // The start-edge cycle counts as tick index 0, so the vote window is centred on mid-bit.
    always_ff @(posedge aclk or negedge arstn) begin
        if (!arstn) begin
            div_cnt <= '0;
            os_cnt  <= '0;
        end else if (start_det) begin
            div_cnt <= '0;
            os_cnt  <= OW'(1);
        end else begin
            div_cnt <= tick ? '0 : div_cnt + 1'b1;
            if (tick) os_cnt <= (os_cnt == OW'(oversample - 1)) ? '0 : os_cnt + 1'b1;
        end
    end

    always_ff @(posedge aclk or negedge arstn) begin
        if (!arstn) state <= IDLE;
        else        state <= next;
    end

    always_comb begin
        next = state;
        done = 1'b0;
        case (state)
            IDLE:   if (start_det) next = START;
            START:  if (decide) next = maj ? IDLE : DATA;
            DATA:   if (decide && bit_cnt == 3'(data_bits - 1))
                        next = (parity_ena != 0) ? PARITY : STOP;
            PARITY: if (decide) next = STOP;
            STOP: begin
                if (decide && bit_cnt == 3'(stop_bits - 1)) begin
                    done = 1'b1;
                    next = ((!maj || ferr) && data_sr == '0) ? BRK : IDLE;
                end
            end
            BRK:    if (rx_s) next = IDLE;
            default: next = IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge arstn) begin
        if (!arstn) begin
            samp    <= 2'b11;
            bit_cnt <= '0;
            data_sr <= '0;
            perr    <= 1'b0;
            ferr    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= done;
            if (tick && os_cnt == OW'(S0)) samp[0] <= rx_s;
            if (tick && os_cnt == OW'(S1)) samp[1] <= rx_s;
            if (start_det) begin
                bit_cnt <= '0;
                data_sr <= '0;
                perr    <= 1'b0;
                ferr    <= 1'b0;
            end else if (decide) begin
                case (state)
                    DATA: begin
                        data_sr <= {maj, data_sr[data_bits-1:1]};
                        bit_cnt <= (next != DATA) ? 3'd0 : bit_cnt + 1'b1;
                    end
                    PARITY: perr <= maj != ((^data_sr) ^ (parity_type != 0));
                    STOP: begin
                        if (!maj) ferr <= 1'b1;
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Word lands one cycle after the final stop decision; a held word wins over a new one.
    always_ff @(posedge aclk or negedge arstn) begin
        if (!arstn) begin
            m_axis_tdata  <= '0;
            m_axis_tuser  <= '0;
            m_axis_tvalid <= 1'b0;
            overflow      <= 1'b0;
        end else begin
            overflow <= 1'b0;
            if (done_q) begin
                if (m_axis_tvalid && !m_axis_tready) begin
                    overflow <= 1'b1;
                end else begin
                    m_axis_tdata  <= 8'(data_sr);
                    m_axis_tuser  <= {perr, ferr};
                    m_axis_tvalid <= 1'b1;
                end
            end else if (m_axis_tvalid && m_axis_tready) begin
                m_axis_tvalid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_util_axis_uart_rx_os.sv
// Directed bench: 8N1 instance (a) and 8E1 instance (b), 64 clk per bit at defaults.
module tb_util_axis_uart_rx_os;
    logic       aclk = 1'b0;
    logic       arstn = 1'b0;
    logic       rx_a = 1'b1, rx_b = 1'b1;
    logic       tready = 1'b1;
    logic [7:0] td_a, td_b;
    logic [1:0] tu_a, tu_b;
    logic       tv_a, tv_b, ovf_a, ovf_b;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int wcnt_a = 0, wcnt_b = 0, ocnt_a = 0, last_cyc_a = 0;
    logic [7:0] wdata_a = 8'h00, wdata_b = 8'h00;
    logic [1:0] wuser_a = 2'b00, wuser_b = 2'b00;

    always #10 aclk = ~aclk;
    always @(posedge aclk) cyc <= cyc + 1;

    util_axis_uart_rx_os u_a (
        .aclk(aclk), .arstn(arstn), .rx(rx_a),
        .m_axis_tdata(td_a), .m_axis_tuser(tu_a), .m_axis_tvalid(tv_a),
        .m_axis_tready(tready), .overflow(ovf_a)
    );

    util_axis_uart_rx_os #(.parity_ena(1), .parity_type(0)) u_b (
        .aclk(aclk), .arstn(arstn), .rx(rx_b),
        .m_axis_tdata(td_b), .m_axis_tuser(tu_b), .m_axis_tvalid(tv_b),
        .m_axis_tready(tready), .overflow(ovf_b)
    );

    // Record every accepted word and every overflow pulse.
    always @(negedge aclk) begin
        if (tv_a && tready) begin
            wcnt_a     <= wcnt_a + 1;
            wdata_a    <= td_a;
            wuser_a    <= tu_a;
            last_cyc_a <= cyc;
        end
        if (tv_b && tready) begin
            wcnt_b  <= wcnt_b + 1;
            wdata_b <= td_b;
            wuser_b <= tu_b;
        end
        if (ovf_a) ocnt_a <= ocnt_a + 1;
    end

    task automatic idle(input int nbits);
        repeat (nbits * 64) @(negedge aclk);
    endtask

    // Drive one frame; glitch inverts one cycle, cut (>0) stops driving after that many cycles.
    task automatic send_frame(input bit sel, input logic [7:0] d, input bit pe, input logic pb,
                              input logic sb, input int glitch, input int cut);
        logic [11:0] fr;
        logic        v;
        int          n;
        fr = '1;
        fr[0] = 1'b0;
        fr[8:1] = d;
        if (pe) begin
            fr[9] = pb; fr[10] = sb; n = 11;
        end else begin
            fr[9] = sb; n = 10;
        end
        for (int i = 0; i < n * 64; i++) begin
            if (cut > 0 && i >= cut) break;
            v = fr[i / 64];
            if (i == glitch) v = ~v;
            if (sel) rx_b = v; else rx_a = v;
            @(negedge aclk);
        end
        if (cut == 0) begin
            if (sel) rx_b = 1'b1; else rx_a = 1'b1;
        end
    endtask

    task automatic test_reset;
        repeat (3) @(negedge aclk);
        checks++; if (tv_a !== 1'b0 || tv_b !== 1'b0) begin errors++; $display("FAIL reset_tvalid got %b%b want 00", tv_a, tv_b); end
        checks++; if (td_a !== 8'h00 || tu_a !== 2'b00) begin errors++; $display("FAIL reset_data got %h/%b want 00/00", td_a, tu_a); end
        checks++; if (ovf_a !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b want 0", ovf_a); end
        arstn = 1'b1;
        idle(2);
    endtask

    task automatic test_basic;
        int wc, t0, lat;
        wc = wcnt_a;
        t0 = cyc;
        send_frame(1'b0, 8'h41, 1'b0, 1'b0, 1'b1, -1, 0);
        idle(1);
        checks++; if (wcnt_a !== wc + 1) begin errors++; $display("FAIL basic_count got %0d want %0d", wcnt_a - wc, 1); end
        checks++; if (wdata_a !== 8'h41 || wuser_a !== 2'b00) begin errors++; $display("FAIL basic_word got %h/%b want 41/00", wdata_a, wuser_a); end
        // 9.5 bit times nominal (608), plus 2-clk synchronizer and the 9/16 decision point.
        lat = last_cyc_a - t0;
        checks++; if (lat < 600 || lat > 624) begin errors++; $display("FAIL basic_latency got %0d want 600..624", lat); end
    endtask

    task automatic test_parity;
        int wc;
        wc = wcnt_b;
        send_frame(1'b1, 8'h55, 1'b1, 1'b0, 1'b1, -1, 0);
        idle(1);
        checks++; if (wcnt_b !== wc + 1 || wdata_b !== 8'h55 || wuser_b !== 2'b00) begin errors++; $display("FAIL parity_good got n=%0d %h/%b want n=1 55/00", wcnt_b - wc, wdata_b, wuser_b); end
        send_frame(1'b1, 8'h55, 1'b1, 1'b1, 1'b1, -1, 0);
        idle(1);
        checks++; if (wcnt_b !== wc + 2 || wdata_b !== 8'h55 || wuser_b !== 2'b10) begin errors++; $display("FAIL parity_bad got n=%0d %h/%b want n=2 55/10", wcnt_b - wc, wdata_b, wuser_b); end
    endtask

    task automatic test_frame_break;
        int wc;
        wc = wcnt_a;
        send_frame(1'b0, 8'hA5, 1'b0, 1'b0, 1'b0, -1, 0);
        idle(2);
        checks++; if (wcnt_a !== wc + 1 || wdata_a !== 8'hA5 || wuser_a !== 2'b01) begin errors++; $display("FAIL frame_err got n=%0d %h/%b want n=1 a5/01", wcnt_a - wc, wdata_a, wuser_a); end
        rx_a = 1'b0;
        idle(20);
        checks++; if (wcnt_a !== wc + 2 || wdata_a !== 8'h00 || wuser_a !== 2'b01) begin errors++; $display("FAIL break_word got n=%0d %h/%b want n=2 00/01", wcnt_a - wc, wdata_a, wuser_a); end
        rx_a = 1'b1;
        idle(3);
        checks++; if (wcnt_a !== wc + 2) begin errors++; $display("FAIL break_quiet got n=%0d want n=2", wcnt_a - wc); end
        send_frame(1'b0, 8'h3C, 1'b0, 1'b0, 1'b1, -1, 0);
        idle(1);
        checks++; if (wcnt_a !== wc + 3 || wdata_a !== 8'h3C || wuser_a !== 2'b00) begin errors++; $display("FAIL after_break got n=%0d %h/%b want n=3 3c/00", wcnt_a - wc, wdata_a, wuser_a); end
    endtask

    task automatic test_glitch;
        int wc;
        wc = wcnt_a;
        rx_a = 1'b0;
        repeat (2) @(negedge aclk);
        rx_a = 1'b1;
        idle(2);
        checks++; if (wcnt_a !== wc || tv_a !== 1'b0) begin errors++; $display("FAIL start_glitch got n=%0d tvalid=%b want n=0 tvalid=0", wcnt_a - wc, tv_a); end
        // 1-clk low pulse at the middle of data bit 3 (frame bit 4).
        send_frame(1'b0, 8'hFF, 1'b0, 1'b0, 1'b1, 4 * 64 + 32, 0);
        idle(1);
        checks++; if (wcnt_a !== wc + 1 || wdata_a !== 8'hFF || wuser_a !== 2'b00) begin errors++; $display("FAIL data_glitch got n=%0d %h/%b want n=1 ff/00", wcnt_a - wc, wdata_a, wuser_a); end
    endtask

    task automatic test_overflow;
        int wc, oc;
        wc = wcnt_a;
        oc = ocnt_a;
        tready = 1'b0;
        send_frame(1'b0, 8'h11, 1'b0, 1'b0, 1'b1, -1, 0);
        send_frame(1'b0, 8'h22, 1'b0, 1'b0, 1'b1, -1, 0);
        idle(1);
        checks++; if (tv_a !== 1'b1 || td_a !== 8'h11) begin errors++; $display("FAIL ovf_hold got tvalid=%b %h want 1 11", tv_a, td_a); end
        checks++; if (ocnt_a !== oc + 1) begin errors++; $display("FAIL ovf_pulses got %0d want 1", ocnt_a - oc); end
        @(posedge aclk);
        #1 tready = 1'b1;
        repeat (3) @(negedge aclk);
        checks++; if (wcnt_a !== wc + 1 || wdata_a !== 8'h11) begin errors++; $display("FAIL ovf_accept got n=%0d %h want n=1 11", wcnt_a - wc, wdata_a); end
        checks++; if (tv_a !== 1'b0) begin errors++; $display("FAIL ovf_drain got tvalid=%b want 0", tv_a); end
    endtask

    task automatic test_reset_midframe;
        int wc;
        send_frame(1'b0, 8'h77, 1'b0, 1'b0, 1'b1, -1, 3 * 64 + 32);
        arstn = 1'b0;
        rx_a = 1'b1;
        repeat (3) @(negedge aclk);
        checks++; if (tv_a !== 1'b0 || td_a !== 8'h00 || tu_a !== 2'b00) begin errors++; $display("FAIL midreset_vals got %b %h/%b want 0 00/00", tv_a, td_a, tu_a); end
        wc = wcnt_a;
        arstn = 1'b1;
        idle(12);
        checks++; if (wcnt_a !== wc) begin errors++; $display("FAIL midreset_partial got n=%0d want 0", wcnt_a - wc); end
        send_frame(1'b0, 8'h12, 1'b0, 1'b0, 1'b1, -1, 0);
        idle(1);
        checks++; if (wcnt_a !== wc + 1 || wdata_a !== 8'h12 || wuser_a !== 2'b00) begin errors++; $display("FAIL midreset_next got n=%0d %h/%b want n=1 12/00", wcnt_a - wc, wdata_a, wuser_a); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_parity();
        test_frame_break();
        test_glitch();
        test_overflow();
        test_reset_midframe();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
